mac_rx_frame_fifo: RTL
======================

Name: mac_rx_frame_fifo

Overview:
Store-and-forward frame buffer on the user side of the MAC receive stream, in the rx_mac_aclk domain. The MAC receive stream has no backpressure; this block absorbs it.
- Frames flagged bad (tuser at tlast) or that overflow the buffer are discarded whole.
- Only complete, error-free frames are presented on a backpressured AXIS master toward the protocol stack (ARP/IP parsers).

Parameters:
C_ADDR_WIDTH, 11, log2 of buffer depth in entries; depth = 2**C_ADDR_WIDTH; usable capacity = depth-1 bytes.
C_CNT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
rx_mac_aclk  in  1  clock; all logic on its rising edge.
rx_mac_reset  in  1  synchronous, active-high reset.
s_axis_tdata  in  8  byte from MAC receive stream.
s_axis_tvalid  in  1  byte valid; no tready, every valid byte must be consumed.
s_axis_tlast  in  1  last byte of frame.
s_axis_tuser  in  1  frame error; meaningful only with tlast.
m_axis_tdata  out  8  buffered frame byte.
m_axis_tvalid  out  1  output byte valid.
m_axis_tlast  out  1  last byte of frame.
m_axis_tready  in  1  downstream accept.
frame_good  out  1  one-cycle pulse when a frame is committed.
frame_drop  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Storage: 9-bit entries {tlast, tdata}, dual-port, one write and one registered read per cycle. Pointers are C_ADDR_WIDTH+1 bits, compared modulo depth, and wrap naturally.
- Pointers:
  - wr_ptr: next write address.
  - wr_commit: end of the last good frame.
  - rd_ptr: next read address.
- Full/empty rules:
  - Full when wr_ptr+1 == rd_ptr (mod depth).
  - Read side sees data only when rd_ptr != wr_commit; uncommitted bytes are never visible.
- Write FSM states: IDLE, WRITE, DISCARD.
  - IDLE/WRITE + valid, not full, not tlast: write byte, wr_ptr++, go to WRITE.
  - Valid + tlast, not full, tuser=0: write byte with last bit, wr_commit <= wr_ptr+1, wr_ptr++, frame_good=1, go to IDLE.
  - Valid + tlast + tuser=1: wr_ptr <= wr_commit, frame_drop=1, go to IDLE.
  - Valid while full, not tlast: go to DISCARD.
  - Valid while full with tlast: rewind wr_ptr <= wr_commit, frame_drop=1, go to IDLE.
  - DISCARD: ignore bytes; on valid+tlast, wr_ptr <= wr_commit, frame_drop=1, go to IDLE.
- Frames longer than depth-1 bytes are always dropped.
- Simultaneous read and write in the same cycle are allowed. Full is evaluated on the registered rd_ptr, so it is conservative by one cycle.
- Read side:
  - RAM read plus one output register (skid-free).
  - Prefetch the next entry whenever the output register is empty or is being accepted (tvalid && tready) and data is available.
  - Sustains 1 byte/cycle with tready held high.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast are held stable.
- Latency: with the buffer empty, the first byte's tvalid rises 2 cycles after the edge that sampled a good tlast.
- Reset (any time, including mid-frame or mid-readout):
  - All pointers go to 0 and the FSM goes to IDLE.
  - Partial frames are lost; unread committed frames are lost.
  - m_axis_tvalid, m_axis_tlast, frame_good and frame_drop go to 0; m_axis_tdata goes to 0.
  - Counters clear to 0.
  - No drop pulse is generated for a frame lost to reset.

Optional Feature:
Macro MAC_RX_FIFO_STATS_EN.
- Defined: adds outputs good_cnt, err_cnt and ovf_cnt, each C_CNT_WIDTH wide, saturating.
  - good_cnt increments on frame_good.
  - err_cnt increments on drops due to tuser.
  - ovf_cnt increments on drops due to full.
  - A frame that overflowed and also ends with tuser counts only in ovf_cnt.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package mac_pkg:
  - FSM state enum {IDLE, WRITE, DISCARD}.
  - Entry-width constant (9).
  - Drop-reason encoding.
- Sub-module mac_sdp_ram: parameterised simple dual-port RAM with registered read. The FIFO control logic stays in the top module.

Test Plan:
- Good frame: 64-byte good frame (tuser=0), tready=1 -> 64 bytes out in order, tlast only on byte 64, one frame_good pulse, tvalid rising 2 cycles after tlast.
- Error frame: 100-byte frame with tuser=1 at tlast, then a 60-byte good frame -> only the 60-byte frame emerges; one frame_drop; wr_ptr rewound (verify via later capacity).
- Overflow: C_ADDR_WIDTH=6, tready=0, 3 good 20-byte frames -> first 3 committed (60 of 63); 4th 20-byte frame overflows -> frame_drop (ovf_cnt=1 with macro); releasing tready yields exactly 60 bytes.
- Exact fit: C_ADDR_WIDTH=6, empty buffer, 63-byte frame accepted; 64-byte frame dropped.
- Backpressure and wrap: 200 back-to-back random frames, random tready 50%, over many wraps -> output byte stream equals scoreboard of good frames; data stable while stalled.
- Reset mid-frame: rx_mac_reset for 1 cycle during byte 30 of 50, with one committed frame unread -> all outputs 0 next cycle, no frames emerge; the next good frame passes normally.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the MAC receive frame FIFO.
//   wr_state_e    : write-side FSM states
//   drop_reason_e : why a frame was discarded (drives the drop pulse and stats)
//   ENTRY_W       : buffer entry width, {tlast, tdata}
package mac_pkg;

  localparam int unsigned ENTRY_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DISCARD
  } wr_state_e;

  typedef enum logic [1:0] {
    DROP_NONE,
    DROP_ERR,
    DROP_OVF
  } drop_reason_e;

endpackage

// File: rtl/mac_rx_frame_fifo_if.sv
// mac_rx_frame_fifo_if: byte-wide AXI-Stream bundle.
//   tdata/tvalid/tlast/tuser : source to sink
//   tready                   : sink to source
//   master modport drives the stream, slave modport receives it.
interface mac_rx_frame_fifo_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/mac_sdp_ram.sv
// mac_sdp_ram: simple dual-port RAM, one write port, one registered read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read enable/address; rdata updates only when re is high
//   rdata        : registered read data (held while re is low)
module mac_sdp_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mac_rx_frame_fifo.sv
// mac_rx_frame_fifo: store-and-forward receive frame buffer (rx_mac_aclk domain).
// Good frames are committed at tlast and only then become readable; frames with
// tuser at tlast or that overflow the buffer are discarded whole.
//   rx_mac_aclk, rx_mac_reset : clock, synchronous active-high reset
//   s_axis (slave)            : MAC receive stream, no backpressure (tready tied 1)
//   m_axis (master)           : buffered frames, backpressured by tready
//   frame_good / frame_drop   : one-cycle commit / discard pulses
// Optional macro MAC_RX_FIFO_STATS_EN adds saturating good_cnt, err_cnt, ovf_cnt.
module mac_rx_frame_fifo
  import mac_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = 11
`ifdef MAC_RX_FIFO_STATS_EN
  ,
  parameter int unsigned C_CNT_WIDTH = 16
`endif
) (
  input  logic                    rx_mac_aclk,
  input  logic                    rx_mac_reset,
  mac_rx_frame_fifo_if.slave      s_axis,
  mac_rx_frame_fifo_if.master     m_axis,
  output logic                    frame_good,
  output logic                    frame_drop
`ifdef MAC_RX_FIFO_STATS_EN
  ,
  output logic [C_CNT_WIDTH-1:0]  good_cnt,
  output logic [C_CNT_WIDTH-1:0]  err_cnt,
  output logic [C_CNT_WIDTH-1:0]  ovf_cnt
`endif
);

  localparam int unsigned PW = C_ADDR_WIDTH + 1;

  wr_state_e    state_q, state_d;
  drop_reason_e drop_reason;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_inc;
  logic          full, avail, ram_we, rd_en, load_out;
  logic          frame_good_q, frame_good_d, frame_drop_q, frame_drop_d;
  logic          ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
  logic [ENTRY_W-1:0] ram_rdata, out_q, out_d;

  assign wr_ptr_inc = wr_ptr_q + PW'(1);
  assign full       = (wr_ptr_inc[C_ADDR_WIDTH-1:0] == rd_ptr_q[C_ADDR_WIDTH-1:0]);
  assign avail      = (rd_ptr_q != wr_commit_q);

  mac_sdp_ram #(.AW(C_ADDR_WIDTH), .DW(ENTRY_W)) u_ram (
    .clk   (rx_mac_aclk),
    .we    (ram_we),
    .waddr (wr_ptr_q[C_ADDR_WIDTH-1:0]),
    .wdata ({s_axis.tlast, s_axis.tdata}),
    .re    (rd_en),
    .raddr (rd_ptr_q[C_ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // Write FSM. Full at tlast is classed as overflow even if tuser is also set.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    ram_we       = 1'b0;
    frame_good_d = 1'b0;
    drop_reason  = DROP_NONE;
    case (state_q)
      IDLE, WRITE: begin
        if (s_axis.tvalid) begin
          if (s_axis.tlast) begin
            state_d = IDLE;
            if (full) begin
              wr_ptr_d    = wr_commit_q;
              drop_reason = DROP_OVF;
            end else if (s_axis.tuser) begin
              wr_ptr_d    = wr_commit_q;
              drop_reason = DROP_ERR;
            end else begin
              ram_we       = 1'b1;
              wr_ptr_d     = wr_ptr_inc;
              wr_commit_d  = wr_ptr_inc;
              frame_good_d = 1'b1;
            end
          end else if (full) begin
            state_d = DISCARD;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            state_d  = WRITE;
          end
        end
      end
      DISCARD: begin
        if (s_axis.tvalid && s_axis.tlast) begin
          wr_ptr_d    = wr_commit_q;
          drop_reason = DROP_OVF;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_drop_d = (drop_reason != DROP_NONE);

  // Read pipeline: RAM read register (ram_vld) feeding the output register.
  // The RAM register only reloads when its content moves on, so it doubles
  // as the prefetch stage and keeps 1 byte/cycle with tready high.
  always_comb begin
    load_out  = ram_vld_q && (!out_vld_q || m_axis.tready);
    rd_en     = avail && (!ram_vld_q || load_out);
    rd_ptr_d  = rd_ptr_q + PW'(rd_en);
    ram_vld_d = rd_en || (ram_vld_q && !load_out);
    out_vld_d = load_out || (out_vld_q && !m_axis.tready);
    out_d     = load_out ? ram_rdata : out_q;
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      frame_good_q <= 1'b0;
      frame_drop_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_good_q <= frame_good_d;
      frame_drop_q <= frame_drop_d;
      ram_vld_q    <= ram_vld_d;
      out_vld_q    <= out_vld_d;
      out_q        <= out_d;
    end
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = out_q[7:0];
  assign m_axis.tlast  = out_q[8];
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tuser  = 1'b0;
  assign frame_good    = frame_good_q;
  assign frame_drop    = frame_drop_q;

`ifdef MAC_RX_FIFO_STATS_EN
  logic [C_CNT_WIDTH-1:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (frame_good_d && (good_cnt_q != '1)) good_cnt_d = good_cnt_q + 1'b1;
    if ((drop_reason == DROP_ERR) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    if ((drop_reason == DROP_OVF) && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule
